// File: rtl/alu_ram_arbiter_if.sv
// Request/response/RAM bus bundle for alu_ram_arbiter.
// slave = arbiter side, master = requesters, response consumer and RAM.
interface alu_ram_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ID_WIDTH   = 3
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [2*NUM_REQ-1:0]          req_op;
  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [15:0]                   page_tbl;

  logic                  resp_valid;
  logic [ID_WIDTH-1:0]   resp_id;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_overflow;
  logic                  resp_ready;

  logic [ADDR_WIDTH-1:0] ram_addra;
  logic [DATA_WIDTH-1:0] ram_dina;
  logic                  ram_wea;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [DATA_WIDTH-1:0] ram_doutb;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, page_tbl, resp_ready, ram_doutb,
    output req_ready, resp_valid, resp_id, resp_data, resp_overflow,
           ram_addra, ram_dina, ram_wea, ram_addrb
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, page_tbl, resp_ready, ram_doutb,
    input  req_ready, resp_valid, resp_id, resp_data, resp_overflow,
           ram_addra, ram_dina, ram_wea, ram_addrb
  );
endinterface

// File: rtl/alu_ram_arbiter.sv
// Round-robin arbiter sharing one stateful-ALU data RAM among NUM_REQ requesters.
// Define ALU_ARB_BOUNDS_CHECK_EN to enable the page-table addr_len bounds check.
module alu_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ID_WIDTH   = 3
) (
  input logic            clk,
  input logic            rst_n,
  alu_ram_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LOADD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_ovf_q, resp_ovf_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;

  logic                  found_c;
  logic [PTR_W-1:0]      win_c;
  logic [PTR_W-1:0]      cand_c;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [ADDR_WIDTH-1:0] phys_c;
  logic [DATA_WIDTH-1:0] incr_c;
  logic                  ovf_c;

`ifdef ALU_ARB_BOUNDS_CHECK_EN
  logic [7:0] len_q, len_d;
  assign ovf_c = 16'(addr_q) > 16'(len_q);
`else
  logic unused_len;
  assign unused_len = ^bus.page_tbl[15:8];
  assign ovf_c = 1'b0;
`endif

  // Cyclic scan from rr_q; first valid requester wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = PTR_W'((32'(rr_q) + k) % NUM_REQ);
      if (!found_c && bus.req_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (rst_n && (state_q == IDLE) && found_c) req_ready_c[win_c] = 1'b1;
  end

  assign win_addr_c = bus.req_addr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
  assign phys_c     = ADDR_WIDTH'(bus.page_tbl[7:0]) + win_addr_c;
  assign incr_c     = bus.ram_doutb + DATA_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_ovf_d   = resp_ovf_q;
    addra_d      = addra_q;
    dina_d       = dina_q;
    wea_d        = 1'b0;
    addrb_d      = addrb_q;
`ifdef ALU_ARB_BOUNDS_CHECK_EN
    len_d        = len_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = READ;
          op_d    = bus.req_op[32'(win_c)*2 +: 2];
          addr_d  = win_addr_c;
          wdata_d = bus.req_wdata[32'(win_c)*DATA_WIDTH +: DATA_WIDTH];
          id_d    = ID_WIDTH'(win_c);
          addrb_d = phys_c;
          rr_d    = (32'(win_c) == NUM_REQ - 1) ? '0 : win_c + PTR_W'(1);
`ifdef ALU_ARB_BOUNDS_CHECK_EN
          len_d   = bus.page_tbl[15:8];
`endif
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        // RAM read data is valid now; result and any write are registered into RESP.
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_ovf_d   = ovf_c;
        resp_data_d  = '0;
        if (!ovf_c) begin
          unique case (op_q)
            OP_LOAD: resp_data_d = bus.ram_doutb;
            OP_STORE: begin
              wea_d       = 1'b1;
              addra_d     = addrb_q;
              dina_d      = wdata_q;
              resp_data_d = wdata_q;
            end
            OP_LOADD: begin
              wea_d       = 1'b1;
              addra_d     = addrb_q;
              dina_d      = incr_c;
              resp_data_d = incr_c;
            end
            default: resp_data_d = '0;
          endcase
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      wea_q        <= 1'b0;
      addrb_q      <= '0;
`ifdef ALU_ARB_BOUNDS_CHECK_EN
      len_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_ovf_q   <= resp_ovf_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      wea_q        <= wea_d;
      addrb_q      <= addrb_d;
`ifdef ALU_ARB_BOUNDS_CHECK_EN
      len_q        <= len_d;
`endif
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_overflow = resp_ovf_q;
  assign bus.ram_addra     = addra_q;
  assign bus.ram_dina      = dina_q;
  assign bus.ram_wea       = wea_q;
  assign bus.ram_addrb     = addrb_q;
endmodule

// File: tb/tb_alu_ram_arbiter.sv
// Bench for alu_ram_arbiter: behavioural arbiter/RAM model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_ram_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned ID_WIDTH   = 3;
`ifdef ALU_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ram_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                       .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  alu_ram_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                    .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: read-first, 1-cycle read latency, not reset.
  logic [DATA_WIDTH-1:0] ram [32];
  always @(posedge clk) begin
    bus.ram_doutb <= ram[bus.ram_addrb];
    if (bus.ram_wea) ram[bus.ram_addra] = bus.ram_dina;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state and logs.
  logic [DATA_WIDTH-1:0] gold [32];
  bit   m_busy = 1'b0;
  int   m_rr = 0, m_acc = 0, m_id = 0, take, age;
  bit   m_we, m_ovf;
  logic [4:0]  m_phys;
  logic [31:0] m_wd, m_data;
  logic [NUM_REQ-1:0] exp_rdy;
  logic [1:0]  t_op;
  logic [4:0]  t_a;
  logic [7:0]  t_base, t_len;
  logic [31:0] t_wd;

  int acc_id_q[$], acc_cyc_q[$], hs_id_q[$], hs_cyc_q[$], wr_cyc_q[$];
  logic [31:0] hs_data_q[$];
  bit hs_ovf_q[$];
  logic [4:0] wr_addr_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 0);
      chk("rst_resp_id", 64'(bus.resp_id), 0);
      chk("rst_resp_data", 64'(bus.resp_data), 0);
      chk("rst_resp_overflow", 64'(bus.resp_overflow), 0);
      chk("rst_ram_wea", 64'(bus.ram_wea), 0);
      chk("rst_ram_addra", 64'(bus.ram_addra), 0);
      chk("rst_ram_dina", 64'(bus.ram_dina), 0);
      chk("rst_ram_addrb", 64'(bus.ram_addrb), 0);
      m_busy = 1'b0;
      m_rr = 0;
    end else begin
      if (bus.ram_wea) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(bus.ram_addra);
      end
      take = -1;
      exp_rdy = '0;
      if (!m_busy)
        for (int k = 0; k < NUM_REQ; k++)
          if (take < 0 && bus.req_valid[(m_rr + k) % NUM_REQ]) take = (m_rr + k) % NUM_REQ;
      if (take >= 0) exp_rdy[take] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (m_busy) begin
        age = cyc - m_acc;
        if (age == 1) chk("ram_addrb", 64'(bus.ram_addrb), 64'(m_phys));
        chk("ram_wea", 64'(bus.ram_wea), 64'(age == 3 && m_we));
        if (age == 3 && m_we) begin
          chk("ram_addra", 64'(bus.ram_addra), 64'(m_phys));
          chk("ram_dina", 64'(bus.ram_dina), 64'(m_wd));
          gold[m_phys] = m_wd;
        end
        chk("resp_valid", 64'(bus.resp_valid), 64'(age >= 3));
        if (age >= 3) begin
          chk("resp_id", 64'(bus.resp_id), 64'(m_id));
          chk("resp_data", 64'(bus.resp_data), 64'(m_data));
          chk("resp_overflow", 64'(bus.resp_overflow), 64'(m_ovf));
          if (bus.resp_ready) begin
            hs_id_q.push_back(int'(bus.resp_id));
            hs_data_q.push_back(bus.resp_data);
            hs_ovf_q.push_back(bus.resp_overflow);
            hs_cyc_q.push_back(cyc);
            m_busy = 1'b0;
          end
        end
      end else begin
        chk("idle_resp_valid", 64'(bus.resp_valid), 0);
        chk("idle_ram_wea", 64'(bus.ram_wea), 0);
      end
      if (take >= 0) begin
        t_op   = bus.req_op[2*take +: 2];
        t_a    = bus.req_addr[ADDR_WIDTH*take +: ADDR_WIDTH];
        t_wd   = bus.req_wdata[DATA_WIDTH*take +: DATA_WIDTH];
        t_base = bus.page_tbl[7:0];
        t_len  = bus.page_tbl[15:8];
        m_phys = 5'((int'(t_base) + int'(t_a)) % 32);
        m_ovf  = BC && (t_a > t_len);
        m_we   = 1'b0;
        m_wd   = '0;
        m_data = '0;
        if (!m_ovf) begin
          case (t_op)
            2'd0: m_data = gold[m_phys];
            2'd1: begin m_we = 1'b1; m_wd = t_wd; m_data = t_wd; end
            2'd2: begin m_we = 1'b1; m_wd = gold[m_phys] + 32'd1; m_data = m_wd; end
            default: m_data = '0;
          endcase
        end
        m_id   = take;
        m_acc  = cyc;
        m_busy = 1'b1;
        m_rr   = (take + 1) % NUM_REQ;
        acc_id_q.push_back(take);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd);
    bus.req_op[2*id +: 2]                   = op;
    bus.req_addr[ADDR_WIDTH*id +: ADDR_WIDTH] = a;
    bus.req_wdata[DATA_WIDTH*id +: DATA_WIDTH] = wd;
  endtask

  task automatic wait_ready(input int id);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[id] && n < 50);
    chk("accept_wait", 64'(bus.req_ready[id]), 1);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_id_q.size() < target && n < 100) begin @(negedge clk); n++; end
    chk("resp_wait", 64'(hs_id_q.size() >= target), 1);
  endtask

  task automatic do_op(input int id, input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd);
    int n0 = hs_id_q.size();
    @(posedge clk); #1;
    set_req(id, op, a, wd);
    bus.req_valid[id] = 1'b1;
    wait_ready(id);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    wait_hs(n0 + 1);
  endtask

  int w0, a0, h0, n;
  logic [31:0] exp2 [3];

  initial begin
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.page_tbl   = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin ram[i] = '0; gold[i] = '0; end
    ram[10] = 32'd5;
    gold[10] = 32'd5;
    exp2[0] = 32'd6; exp2[1] = 32'd7; exp2[2] = 32'd8;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Store then load through a full-range page.
    bus.page_tbl = 16'h1F00;
    w0 = wr_cyc_q.size();
    do_op(2, 2'b01, 5'd3, 32'hDEADBEEF);
    chk("t1_wea_count", 64'(wr_cyc_q.size() - w0), 1);
    chk("t1_wea_latency", 64'(wr_cyc_q[$] - acc_cyc_q[$]), 3);
    chk("t1_addra", 64'(wr_addr_q[$]), 3);
    do_op(2, 2'b00, 5'd3, 32'h0);
    chk("t1_load_data", 64'(hs_data_q[$]), 64'h0DEADBEEF);
    chk("t1_load_id", 64'(hs_id_q[$]), 2);

    // Three loadd on base 8 + addr 2 -> RAM[10] 5 -> 6,7,8.
    bus.page_tbl = 16'h0408;
    for (int k = 0; k < 3; k++) begin
      do_op(0, 2'b10, 5'd2, 32'h0);
      chk("t2_loadd_data", 64'(hs_data_q[$]), 64'(exp2[k]));
    end
    chk("t2_ram10", 64'(ram[10]), 8);

    // Reset one cycle after accepting a loadd: write dropped.
    w0 = wr_cyc_q.size();
    @(posedge clk); #1;
    set_req(3, 2'b10, 5'd2, 32'h0);
    bus.req_valid[3] = 1'b1;
    wait_ready(3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t6_req_ready_in_reset", 64'(bus.req_ready), 0);
    chk("t6_resp_valid", 64'(bus.resp_valid), 0);
    repeat (3) @(posedge clk);
    #1 bus.req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t6_no_write", 64'(wr_cyc_q.size() - w0), 0);
    chk("t6_ram10", 64'(ram[10]), 8);

    // All four requesters valid: order 0,1,2,3,0 spaced 4 cycles.
    bus.page_tbl = 16'h1F00;
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 5'(i), 32'h0);
    a0 = acc_id_q.size();
    h0 = hs_id_q.size();
    @(posedge clk); #1 bus.req_valid = 4'hF;
    n = 0;
    while (acc_id_q.size() < a0 + 5 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.req_valid = '0;
    wait_hs(h0 + 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_grant_order", 64'(acc_id_q[a0 + k]), 64'(k % 4));
      if (k > 0) chk("t3_spacing", 64'(acc_cyc_q[a0 + k] - acc_cyc_q[a0 + k - 1]), 4);
    end

    // Bounds: len 4, base 16; addr 5 overflows when checking, addr 4 is legal.
    bus.page_tbl = 16'h0410;
    w0 = wr_cyc_q.size();
    do_op(1, 2'b01, 5'd5, 32'h12345678);
`ifdef ALU_ARB_BOUNDS_CHECK_EN
    chk("t4_ovf", 64'(hs_ovf_q[$]), 1);
    chk("t4_ovf_data", 64'(hs_data_q[$]), 0);
    chk("t4_ovf_no_write", 64'(wr_cyc_q.size() - w0), 0);
`else
    chk("t4_ovf", 64'(hs_ovf_q[$]), 0);
    chk("t4_wrap_data", 64'(hs_data_q[$]), 64'h12345678);
    chk("t4_write", 64'(ram[21]), 64'h12345678);
`endif
    do_op(1, 2'b01, 5'd4, 32'hCAFEF00D);
    chk("t4_edge_ovf", 64'(hs_ovf_q[$]), 0);
    chk("t4_edge_write", 64'(ram[20]), 64'hCAFEF00D);

    // Backpressure: resp_ready low for 5 RESP cycles.
    bus.page_tbl = 16'h1F00;
    bus.resp_ready = 1'b0;
    w0 = wr_cyc_q.size();
    h0 = hs_id_q.size();
    set_req(0, 2'b00, 5'd0, 32'h0);
    @(posedge clk); #1;
    set_req(2, 2'b01, 5'd1, 32'hA5A5A5A5);
    bus.req_valid[2] = 1'b1;
    wait_ready(2);
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 20);
    chk("t5_resp_seen", 64'(bus.resp_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    bus.req_valid = '0;
    wait_hs(h0 + 1);
    chk("t5_hs_latency", 64'(hs_cyc_q[$] - acc_cyc_q[$]), 8);
    chk("t5_single_wea", 64'(wr_cyc_q.size() - w0), 1);
    chk("t5_data", 64'(hs_data_q[$]), 64'hA5A5A5A5);
    chk("t5_ram1", 64'(ram[1]), 64'hA5A5A5A5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ram_arbiter.md
# alu_ram_arbiter

Round-robin arbiter that shares one stateful-ALU data RAM (32-word, 1-cycle read latency, dual-port: write port A, read port B) among several ALU requesters in an action stage. Each granted request is a load, store or loadd (read-increment-write), translated through the tenant page table (`{addr_len, base_addr}`) and bounds-checked. Exactly one operation is in flight at a time, so read-after-write hazards cannot occur. Sits between the per-container ALUs and the `blk_mem_gen_0` instance they would otherwise own privately.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 32, RAM word width
- `ADDR_WIDTH`, 5, RAM address width
- `ID_WIDTH`, 3, width of `resp_id`; must be ≥ clog2(`NUM_REQ`)

Ports:
- `clk`  in  1  clock, single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  `NUM_REQ`  per-requester request valid
- `req_op`  in  2×`NUM_REQ`  op code: 00 load, 01 store, 10 loadd, 11 nop
- `req_addr`  in  `ADDR_WIDTH`×`NUM_REQ`  tenant-relative word address
- `req_wdata`  in  `DATA_WIDTH`×`NUM_REQ`  store data
- `req_ready`  out  `NUM_REQ`  one-hot accept
- `page_tbl`  in  16  `{addr_len[15:8], base_addr[7:0]}`
- `resp_valid`  out  1  response valid
- `resp_id`  out  `ID_WIDTH`  index of the requester being answered
- `resp_data`  out  `DATA_WIDTH`  result
- `resp_overflow`  out  1  address exceeded `addr_len`
- `resp_ready`  in  1  response consumer ready
- `ram_addra`  out  `ADDR_WIDTH`  write address
- `ram_dina`  out  `DATA_WIDTH`  write data
- `ram_wea`  out  1  write enable
- `ram_addrb`  out  `ADDR_WIDTH`  read address
- `ram_doutb`  in  `DATA_WIDTH`  read data, valid 1 cycle after `ram_addrb`

## Operation
- FSM states: IDLE → READ → EXEC → RESP → IDLE.
- IDLE: the winner is the first index `i` with `req_valid[i]=1`, scanning cyclically from `rr_ptr`. `req_ready` is combinational: one-hot on the winner in IDLE, otherwise 0, and forced to 0 while `rst_n`=0.
- On accept, capture op, addr, wdata, id and `page_tbl`, then set `rr_ptr` ← winner+1 mod `NUM_REQ`.
- READ: `ram_addrb` ← (base_addr + addr) truncated to `ADDR_WIDTH`; physical addresses wrap.
- EXEC: `ram_doutb` is valid this cycle. Overflow is true when addr > addr_len (strict; addr == addr_len is legal).
  - load: `resp_data` = dout, no write.
  - store: write wdata; `resp_data` = wdata.
  - loadd: write dout+1 (mod 2^`DATA_WIDTH`); `resp_data` = dout+1.
  - nop: no write; `resp_data` = 0.
  - overflow: no write; `resp_data` = 0; `resp_overflow` = 1.
- RESP: `resp_valid`=1 and `resp_id`, `resp_data` and `resp_overflow` stay stable until `resp_ready`=1, then the FSM returns to IDLE.
- `req_valid` may drop at any time while not granted. Only the accept cycle matters.

## Timing
- Reset values: state IDLE, `rr_ptr`=0; `resp_valid`, `resp_id`, `resp_data`, `resp_overflow`, `ram_wea`, `ram_addra`, `ram_dina` and `ram_addrb` all 0.
- Accept at cycle T. `ram_addrb` is valid at T+1. EXEC at T+2. At T+3 `resp_valid`=1 and, if writing, `ram_wea`=1 for exactly one cycle with `ram_addra`/`ram_dina`.
- With `resp_ready` held high, the next accept is at T+4. Peak throughput is 1 op per 4 cycles.
- The write at T+3 always precedes the next read (≥T+5), so back-to-back loadd to the same address always observes the prior write.
- Backpressure: each cycle `resp_ready`=0 in RESP adds one cycle. `ram_wea` still pulses only once.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and the in-flight write is dropped if `ram_wea` has not yet pulsed.

## Configuration
- `ALU_ARB_BOUNDS_CHECK_EN` defined: page-table bounds check is active as described.
- `ALU_ARB_BOUNDS_CHECK_EN` undefined: no comparison logic; `resp_overflow` is constant 0 and every op executes at base+addr (wrapped).

## Test plan
- Reset, page_tbl=0x1F00, requester 2 store addr 3 data 0xDEADBEEF, then load addr 3 → `ram_wea` at T+3 with addra=3, load returns 0xDEADBEEF with `resp_id`=2.
- page_tbl={len=4, base=8}, loadd addr 2 three times, starting from RAM[10]=5 → responses 6, 7, 8; RAM[10]=8.
- All 4 requesters valid continuously, `resp_ready`=1 → grant order 0,1,2,3,0 with accepts spaced 4 cycles.
- Bounds check enabled, len=4, store addr 5 → `resp_overflow`=1, `resp_data`=0, `ram_wea` never asserts. Same address 4 → write occurs.
- Hold `resp_ready`=0 for 5 cycles in RESP → `resp_*` stable and `req_ready` all 0; response completes on the 6th cycle with a single `ram_wea` pulse.
- Deassert `rst_n` one cycle after accepting a loadd → `ram_wea` never pulses, all outputs are 0, `rr_ptr` restarts at 0.
